lcv_div_seq: RTL
================

# lcv_div_seq

Iterative radix-2 restoring divider, the inverse of the DSP multiply-accumulate blocks. It takes a WIDTH_NUM-bit dividend and a WIDTH_DEN-bit divisor and produces a quotient and remainder after a fixed latency, one quotient bit per cycle. It sits beside the multiply-accumulate units in the arithmetic datapath for fixed-point normalisation and scaling, where a DSP-based divide is not available. Valid/ready handshakes are used on both sides.

## Interface
- WIDTH_NUM, 32: dividend and quotient width; must be ≥ WIDTH_DEN.
- WIDTH_DEN, 16: divisor and remainder width; must be ≥ 2.
- SIGNED, 1: 1 = two's-complement truncating division; 0 = unsigned.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- inp_valid  in  1  operands present.
- inp_ready  out  1  block can accept operands.
- num  in  WIDTH_NUM  dividend.
- den  in  WIDTH_DEN  divisor.
- outp_valid  out  1  result present.
- outp_ready  in  1  consumer accepts result.
- quo  out  WIDTH_NUM  quotient.
- rem  out  WIDTH_DEN  remainder.
- dbz  out  1  divide-by-zero flag, qualified by outp_valid.

## Operation
- States: IDLE, RUN, FIX, DONE. inp_ready = (state == IDLE). outp_valid = (state == DONE). Both are registered.
- IDLE: on the edge where inp_valid && inp_ready, latch the operands and go to RUN.
  - In signed mode, latch |num|, |den|, sign(num) and sign(num)^sign(den).
  - Latch den==0 into a dbz register. Clear the partial remainder (WIDTH_DEN+1 bits) and the iteration counter.
- RUN: one restoring step per edge, MSB of the dividend magnitude first.
  - Shift the remainder left and bring in the next dividend bit.
  - Trial-subtract |den|. If non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - After exactly WIDTH_NUM steps, go to FIX.
- FIX (one edge): apply signs and load quo, rem.
  - Negate the quotient if the quotient sign is 1.
  - Negate the remainder if sign(num) is 1, so the remainder sign follows the dividend (C semantics).
  - Go to DONE.
- DONE: hold quo, rem and dbz stable. On the edge where outp_ready is 1, go to IDLE. quo, rem and dbz keep their values until the next FIX.
- Divide by zero (den == 0): follows the same state path and latency. Result is quo = all ones, rem = low WIDTH_DEN bits of num, dbz = 1. This applies in both SIGNED modes.
- Signed overflow (num = -2^(WIDTH_NUM-1), den = -1): quo = -2^(WIDTH_NUM-1) (wraps), rem = 0, dbz = 0.
- Magnitudes are held unsigned at full width, so |−2^(WIDTH_NUM-1)| is exact.
- Invariant when dbz = 0: num == quo*den + rem (modulo 2^WIDTH_NUM), with |rem| < |den|.
- Inputs are ignored outside IDLE. The block holds at most one operation; there is no overlap and no queueing.

## Timing
- Reset (async assert, sync release) drives: state IDLE, inp_ready 1, outp_valid 0, quo 0, rem 0, dbz 0, counter 0.
- Accept at edge E0. RUN steps occur on edges E1..E(WIDTH_NUM). FIX occurs at edge E(WIDTH_NUM+1).
- outp_valid rises after edge E(WIDTH_NUM+1). Latency from accept to valid is WIDTH_NUM+1 cycles (33 at defaults) and is identical for every operand.
- If outp_ready is already 1 when outp_valid rises, the result is consumed on the next edge. inp_ready is 1 in the cycle after that. Minimum initiation interval is WIDTH_NUM+3 cycles.
- outp_ready held low stalls DONE indefinitely. quo, rem and dbz must not change while stalled.
- If rst asserts in RUN, FIX or DONE, the operation is aborted immediately and all outputs take their reset values. A result is never emitted after a reset.

## Test plan
- SIGNED=1, num=1000, den=7 → quo=142, rem=6, dbz=0. outp_valid rises exactly 33 cycles after accept.
- Signed corner cases (num, den → quo, rem), all with dbz=0:
  - −1000, 7 → −142, −6.
  - 1000, −7 → −142, 6.
  - −1000, −7 → 142, −6.
- num=0x80000000, den=0xFFFF (−1) → quo=0x80000000, rem=0, dbz=0. Then num=0x12345678, den=0 → quo=0xFFFFFFFF, rem=0x5678, dbz=1.
- SIGNED=0, num=0xFFFFFFFF, den=0xFFFF → quo=0x00010001, rem=0. Then den=1 → quo=0xFFFFFFFF, rem=0.
- Backpressure: hold outp_ready=0 for 10 cycles in DONE → outp_valid stays 1 and quo/rem stay stable, inp_ready stays 0, and inp_valid pulses are ignored. Release outp_ready → one handshake, and inp_ready=1 the next cycle.
- Assert rst mid-RUN (cycle 15) → all outputs at reset values immediately, and no outp_valid follows. A new 100/3 after reset → quo=33, rem=1.

Source files
------------

// File: rtl/lcv_div_seq_if.sv
// Operand/result handshake bundle for lcv_div_seq.
// Valid/ready on both the operand and the result side.
interface lcv_div_seq_if #(
  parameter int WIDTH_NUM = 32,
  parameter int WIDTH_DEN = 16
);
  logic                 inp_valid;
  logic                 inp_ready;
  logic [WIDTH_NUM-1:0] num;
  logic [WIDTH_DEN-1:0] den;
  logic                 outp_valid;
  logic                 outp_ready;
  logic [WIDTH_NUM-1:0] quo;
  logic [WIDTH_DEN-1:0] rem;
  logic                 dbz;

  modport master (
    output inp_valid, num, den, outp_ready,
    input  inp_ready, outp_valid, quo, rem, dbz
  );

  modport slave (
    input  inp_valid, num, den, outp_ready,
    output inp_ready, outp_valid, quo, rem, dbz
  );
endinterface

// File: rtl/lcv_div_seq.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Signed mode divides magnitudes and fixes signs in a final step.
module lcv_div_seq #(
  parameter int WIDTH_NUM = 32,
  parameter int WIDTH_DEN = 16,
  parameter int SIGNED    = 1
) (
  input logic         clk,
  input logic         rst,
  lcv_div_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH_NUM + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           r_state;
  logic                 r_inp_ready;
  logic                 r_outp_valid;
  logic [WIDTH_NUM-1:0] r_acc;
  logic [WIDTH_DEN:0]   r_prem;
  logic [WIDTH_DEN-1:0] r_den;
  logic [WIDTH_DEN-1:0] r_num_lo;
  logic                 r_sn;
  logic                 r_sq;
  logic                 r_dz;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH_NUM-1:0] r_quo;
  logic [WIDTH_DEN-1:0] r_rem;
  logic                 r_dbz;

  logic                 w_num_neg;
  logic                 w_den_neg;
  logic [WIDTH_NUM-1:0] w_num_mag;
  logic [WIDTH_DEN-1:0] w_den_mag;
  logic [WIDTH_DEN:0]   w_shift;
  logic [WIDTH_DEN+1:0] w_diff;
  logic                 w_ge;
  logic                 w_last;
  logic [WIDTH_NUM-1:0] w_quo_fix;
  logic [WIDTH_DEN-1:0] w_rem_fix;

  assign bus.inp_ready  = r_inp_ready;
  assign bus.outp_valid = r_outp_valid;
  assign bus.quo        = r_quo;
  assign bus.rem        = r_rem;
  assign bus.dbz        = r_dbz;

  always_comb begin
    w_num_neg = (SIGNED != 0) && bus.num[WIDTH_NUM-1];
    w_den_neg = (SIGNED != 0) && bus.den[WIDTH_DEN-1];
    w_num_mag = w_num_neg ? -bus.num : bus.num;
    w_den_mag = w_den_neg ? -bus.den : bus.den;
    // Partial remainder gains the next dividend bit from the shifting accumulator
    w_shift   = {r_prem[WIDTH_DEN-1:0], r_acc[WIDTH_NUM-1]};
    w_diff    = {1'b0, w_shift} - {2'b00, r_den};
    w_ge      = ~w_diff[WIDTH_DEN+1];
    w_last    = (r_cnt == CW'(WIDTH_NUM - 1));
    w_quo_fix = r_sq ? -r_acc : r_acc;
    w_rem_fix = r_sn ? -r_prem[WIDTH_DEN-1:0] : r_prem[WIDTH_DEN-1:0];
    if (r_dz) begin
      w_quo_fix = '1;
      w_rem_fix = r_num_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_inp_ready  <= 1'b1;
      r_outp_valid <= 1'b0;
      r_acc        <= '0;
      r_prem       <= '0;
      r_den        <= '0;
      r_num_lo     <= '0;
      r_sn         <= 1'b0;
      r_sq         <= 1'b0;
      r_dz         <= 1'b0;
      r_cnt        <= '0;
      r_quo        <= '0;
      r_rem        <= '0;
      r_dbz        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.inp_valid) begin
            r_acc       <= w_num_mag;
            r_den       <= w_den_mag;
            r_num_lo    <= bus.num[WIDTH_DEN-1:0];
            r_sn        <= w_num_neg;
            r_sq        <= w_num_neg ^ w_den_neg;
            r_dz        <= (bus.den == '0);
            r_prem      <= '0;
            r_cnt       <= '0;
            r_inp_ready <= 1'b0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          r_prem <= w_ge ? w_diff[WIDTH_DEN:0] : w_shift;
          r_acc  <= {r_acc[WIDTH_NUM-2:0], w_ge};
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          r_quo        <= w_quo_fix;
          r_rem        <= w_rem_fix;
          r_dbz        <= r_dz;
          r_outp_valid <= 1'b1;
          r_state      <= S_DONE;
        end
        default: begin
          if (bus.outp_ready) begin
            r_outp_valid <= 1'b0;
            r_inp_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule
